// File: rtl/ifetch_queue.sv
// ifetch_queue
// Instruction fetch front end for the single-cycle datapath. It generates
// sequential word-aligned fetch addresses, issues them to instruction memory
// over a req/ack handshake, buffers returned words with their PC in a small
// circular FIFO and presents them to decode over valid/ready. A redirect
// flushes the queue and restarts fetch at a new PC.
//
// Optional feature macro: IFETCH_BYPASS_EN
//   When defined, a word acked while the queue is empty is forwarded straight
//   to the output in the ack cycle (and not stored if it is consumed then).
//
// Parameters:
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect          flush queue, restart fetch at redirect_pc
//   redirect_pc       new fetch address (bits [1:0] ignored)
//   imem_req          fetch request to instruction memory
//   imem_addr         fetch address, held while imem_req=1 and imem_ack=0
//   imem_ack          request completes this cycle
//   imem_rdata        instruction word returned with imem_ack
//   out_valid         out_pc/out_instr hold a valid instruction
//   out_ready         consumer accepts the presented instruction
//   out_pc, out_instr PC and word of the presented instruction
//   occupancy         number of queued entries

module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL,
        DRAIN
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [31:0]    fetch_pc;
    logic [31:0]    drain_addr;
    logic [31:0]    pc_mem    [DEPTH];
    logic [31:0]    instr_mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic [AW:0]    next_count;

    logic           fifo_nonempty;
    logic           flush;
    logic           bypass;
    logic           bypass_taken;
    logic           push;
    logic           pop;
    logic [31:0]    redirect_target;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign fifo_nonempty   = (count != '0);
    // Redirect is ignored during the single IDLE cycle after reset.
    assign flush           = redirect && (state != IDLE);

    assign imem_req  = (state == REQ) || (state == DRAIN);
    // While draining, the abandoned request's address must stay on the bus
    // until memory acks it; fetch_pc already holds the redirect target.
    assign imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;

`ifdef IFETCH_BYPASS_EN
    assign bypass = (state == REQ) && imem_ack && !redirect && !fifo_nonempty;
`else
    assign bypass = 1'b0;
`endif
    assign bypass_taken = bypass && out_ready;

    assign out_valid = fifo_nonempty || bypass;
    assign occupancy = count;
    assign pop       = fifo_nonempty && out_ready;
    assign push      = (state == REQ) && imem_ack && !redirect && !bypass_taken;

    // Presented instruction: FIFO head, else the bypassed ack word, else zero.
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (fifo_nonempty) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end else if (bypass) begin
            out_pc    = fetch_pc;
            out_instr = imem_rdata;
        end
    end

    // Occupancy after this cycle's push/pop, or zero when flushed.
    always_comb begin
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else begin
            next_count = count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In DRAIN an ack retires the abandoned request even if another redirect
    // arrives in the same cycle; that redirect only retargets fetch_pc.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = REQ;
            REQ: begin
                if (redirect) begin
                    next_state = imem_ack ? REQ : DRAIN;
                end else if (next_count == FULL_COUNT) begin
                    next_state = FULL;
                end else begin
                    next_state = REQ;
                end
            end
            FULL: begin
                if (redirect || (next_count != FULL_COUNT)) begin
                    next_state = REQ;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    next_state = REQ;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Fetch address, drain address, queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            count <= next_count;
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= redirect_target;
                if ((state == REQ) && !imem_ack) begin
                    drain_addr <= fetch_pc;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if ((state == REQ) && imem_ack) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end
        end
    end

    // Queue storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue
// Self-checking bench for ifetch_queue (DEPTH=4, RESET_PC=0). A queue-based
// reference model predicts every output each cycle; a vector table and a few
// hand-written sequences pin down the fill/full/redirect corner cases, and a
// randomized phase exercises resets, redirects, memory stalls and
// back-pressure. Honours IFETCH_BYPASS_EN when defined.

module tb_ifetch_queue;

    localparam int DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   imem_req;
    logic [31:0]            imem_addr;
    logic                   imem_ack;
    logic [31:0]            imem_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_pc;
    logic [31:0]            out_instr;
    logic [$clog2(DEPTH):0] occupancy;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .occupancy   (occupancy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: fetcher status plus a queue of buffered PCs.
    bit          m_known;
    bit          m_idle;
    bit          m_drain;
    logic [31:0] m_fpc;
    logic [31:0] m_drain_addr;
    logic [31:0] m_q[$];

    bit          e_req;
    logic [31:0] e_addr;
    bit          e_byp;
    bit          e_valid;
    logic [31:0] e_pc;

    typedef struct {
        bit          redir;
        logic [31:0] rpc;
        bit          ack;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        int          e_occ;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare all outputs against the model
    // mid-cycle, then advance the model by the rules of the fetch queue.
    task automatic applyStimulus(input bit r, input bit rd, input logic [31:0] rpc,
                                 input bit ack, input bit rdy);
        @(posedge clk);
        #1;
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        out_ready   = rdy;
        e_req   = m_known && !m_idle && (m_drain || (m_q.size() < DEPTH));
        e_addr  = m_drain ? m_drain_addr : m_fpc;
        imem_rdata = instr_of(e_addr);
        e_byp   = BYP && e_req && !m_drain && ack && !rd && (m_q.size() == 0);
        e_valid = (m_q.size() != 0) || e_byp;
        e_pc    = (m_q.size() != 0) ? m_q[0] : (e_byp ? m_fpc : 32'h0);
        @(negedge clk);
        if (m_known) begin
            checkOutput("imem_req", {31'b0, imem_req}, {31'b0, e_req});
            if (e_req) begin
                checkOutput("imem_addr", imem_addr, e_addr);
            end
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
            checkOutput("out_pc", out_pc, e_pc);
            checkOutput("out_instr", out_instr, e_valid ? instr_of(e_pc) : 32'h0);
            checkOutput("occupancy", 32'(occupancy), 32'(m_q.size()));
        end
        if (r) begin
            m_known      = 1'b1;
            m_idle       = 1'b1;
            m_drain      = 1'b0;
            m_fpc        = 32'h0;
            m_drain_addr = 32'h0;
            m_q.delete();
        end else if (m_known) begin
            if (m_idle) begin
                m_idle = 1'b0;
            end else begin
                if (rdy && (m_q.size() > 0)) begin
                    m_q.delete(0);
                end
                if (rd) begin
                    if (m_drain) begin
                        if (ack) m_drain = 1'b0;
                    end else if (e_req && !ack) begin
                        m_drain      = 1'b1;
                        m_drain_addr = m_fpc;
                    end
                    m_q.delete();
                    m_fpc = {rpc[31:2], 2'b00};
                end else if (m_drain) begin
                    if (ack) m_drain = 1'b0;
                end else if (e_req && ack) begin
                    if (!(e_byp && rdy)) m_q.push_back(m_fpc);
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        int          first;
        int          wait_cnt;
        bit          redirected;
        bit          saw8;
        bit          got_first;
        bit          pre_req;
        logic [31:0] pre_addr;
        bit          r;
        bit          rd;
        bit          ack;
        bit          rdy;
        logic [31:0] rpc;

        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; out_ready = 1'b0;
        m_known = 1'b0; m_idle = 1'b1; m_drain = 1'b0;
        m_fpc = '0; m_drain_addr = '0;

        // Fill to full with a stalled consumer, release one slot, push and
        // pop together at 3/4, then redirect to an unaligned PC mid-request.
        tbl[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0,  32'h0, 0};
        tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0,   BYP,   32'h0, 0};
        tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h4,   1'b1,  32'h0, 1};
        tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h8,   1'b1,  32'h0, 2};
        tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'hC,   1'b1,  32'h0, 3};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b1,  32'h0, 4};
        tbl[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b1,  32'h0, 4};
        tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h10,  1'b1,  32'h4, 3};
        tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h10,  1'b1,  32'h4, 3};
        tbl[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h14,  1'b1,  32'h8, 3};
        tbl[10] = '{1'b1, 32'h203, 1'b0, 1'b0, 1'b1, 32'h14,  1'b1,  32'h8, 3};
        tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h14,  1'b0,  32'h0, 0};
        tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h14,  1'b0,  32'h0, 0};
        tbl[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h200, 1'b0,  32'h0, 0};
        tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h200, BYP,   BYP ? 32'h200 : 32'h0, 0};
        tbl[15] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h204, !BYP,  BYP ? 32'h0 : 32'h200, BYP ? 0 : 1};

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < NV; i++) begin
            applyStimulus(1'b0, tbl[i].redir, tbl[i].rpc, tbl[i].ack, tbl[i].ready);
            checkOutput($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) begin
                checkOutput($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            end
            checkOutput($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
            checkOutput($sformatf("tbl%0d_pc", i), out_pc, tbl[i].e_pc);
            checkOutput($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
            if (tbl[i].e_valid) begin
                checkOutput($sformatf("tbl%0d_instr", i), out_instr, instr_of(tbl[i].e_pc));
            end
        end

        // Zero-wait memory with an always-ready consumer: one word per cycle.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (out_valid && (first < 0)) first = k;
            if (first > 0) begin
                checkOutput("zw_valid", {31'b0, out_valid}, 32'h1);
                checkOutput("zw_pc", out_pc, 32'((k - first) * 4));
            end
        end
        checkOutput("zw_first_valid", 32'(first), BYP ? 32'd2 : 32'd3);

        // Three-cycle memory, redirect to 0x100 one cycle into the 0x8 fetch.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_cnt = 0; redirected = 1'b0; saw8 = 1'b0; got_first = 1'b0;
        for (int k = 0; (k < 40) && !got_first; k++) begin
            pre_req  = !m_idle && (m_drain || (m_q.size() < DEPTH));
            pre_addr = m_drain ? m_drain_addr : m_fpc;
            ack      = pre_req && (wait_cnt == 2);
            rd       = !redirected && pre_req && !m_drain && (pre_addr == 32'h8) && (wait_cnt == 1);
            applyStimulus(1'b0, rd, 32'h100, ack, 1'b1);
            if (redirected && out_valid && (out_pc == 32'h8)) saw8 = 1'b1;
            if (redirected && out_valid && !got_first) begin
                checkOutput("lat_first_pc", out_pc, 32'h100);
                got_first = 1'b1;
            end
            if (rd) redirected = 1'b1;
            if (pre_req) wait_cnt = ack ? 0 : wait_cnt + 1;
        end
        checkOutput("lat_got_word", {31'b0, got_first}, 32'h1);
        checkOutput("lat_no_0x8", {31'b0, saw8}, 32'h0);

        // Reset while draining an abandoned request.
        applyStimulus(1'b1, 1'b0, 32'h0,  1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0,  1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0,  1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0,  1'b0, 1'b1);
        checkOutput("drn_req", {31'b0, imem_req}, 32'h1);
        checkOutput("drn_addr", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("rst_drn_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_drn_occ", 32'(occupancy), 32'h0);
        checkOutput("rst_drn_valid", {31'b0, out_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("restart_req", {31'b0, imem_req}, 32'h1);
        checkOutput("restart_addr", imem_addr, 32'h0);

        // Randomized traffic including address wrap near 0xFFFFFFFC.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            rd  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 | ($urandom & 32'hF));
            ack = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < ((((i / 500) % 2) == 1) ? 85 : 30));
            applyStimulus(r, rd, rpc, ack, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
